clic_dispatch: RTL and testbench
================================

CLIC_DISPATCH -- requirements
Module: clic_dispatch

Interface
REQ-001 SHALL have parameter NrSources, default 4, number of interrupt sources.
REQ-002 SHALL have parameter PrioWidth, default 3, priority/threshold width.
REQ-003 SHALL have parameter Depth, default 4, maximum nesting depth (threshold stack entries).
REQ-004 SHALL derive SrcWidth = $clog2(NrSources) and LvlWidth = $clog2(Depth+1).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 index  in  SrcWidth  winner index from arbiter.
REQ-008 is_interrupt  in  1  arbiter has a winner above current threshold.
REQ-009 win_prio  in  PrioWidth  priority of winner.
REQ-010 irq_ready  in  1  core accepts offered interrupt.
REQ-011 mret  in  1  core returns from current handler (one-cycle pulse).
REQ-012 t  out  PrioWidth  current threshold, fed back to arbiter.
REQ-013 irq_valid  out  1  interrupt offered to core.
REQ-014 irq_id  out  SrcWidth  offered interrupt index.
REQ-015 clr_pending  out  NrSources  one-hot, one-cycle pending-clear pulse.
REQ-016 level  out  LvlWidth  current nesting depth.
REQ-017 err  out  1  sticky: mret with empty stack.

Function
REQ-018 SHALL implement states IDLE and OFFER; all outputs registered.
REQ-019 IDLE: is_interrupt=1 and level<Depth -> capture index/win_prio, go OFFER; irq_valid=1 from next cycle.
REQ-020 IDLE with level==Depth SHALL ignore is_interrupt (no offer).
REQ-021 OFFER: irq_valid, irq_id, captured prio held stable until irq_ready=1; arbiter changes ignored.
REQ-022 Handshake (OFFER, irq_ready=1): push t, t<=captured prio, level+1, clr_pending[irq_id]=1 next cycle only, irq_valid=0 next cycle, go IDLE.
REQ-023 mret with level>0 (any state): pop, t<=popped value, level-1, next cycle.
REQ-024 mret and handshake same cycle: pop then push; net level unchanged, stack top unchanged, t<=captured prio.
REQ-025 mret with level==0: no stack change, t unchanged, err<=1 (sticky until reset).
REQ-026 Minimum latency is_interrupt rise -> irq_valid: 1 cycle; handshake -> new t: 1 cycle; back-to-back offer possible from cycle after handshake.
REQ-027 Priority comparisons unsigned, PrioWidth bits; t never exceeds 2^PrioWidth-1; no wrap.
REQ-028 clr_pending SHALL be all-zero except the single handshake-following cycle.

Reset
REQ-029 rst_n=0 SHALL asynchronously force: state IDLE, t=0, level=0, irq_valid=0, irq_id=0, clr_pending=0, err=0, stack entries 0.
REQ-030 Reset during OFFER SHALL drop the offer without clr_pending pulse.
REQ-031 Release SHALL be synchronous to clk; first action possible on first rising edge after release.

Structure
REQ-032 Shared package clic_pkg SHALL hold the state enum (IDLE, OFFER) and default width constants.
REQ-033 Threshold LIFO SHALL be sub-module clic_prio_stack (push, pop, data in/out, level, full, empty; simultaneous push+pop = replace top).
REQ-034 clic_dispatch SHALL contain only FSM, capture registers and clr_pending decode.

Verification
REQ-035 Reset, then is_interrupt=1, index=2, win_prio=5, irq_ready=1 next cycle -> irq_valid one cycle, irq_id=2, then t=5, level=1, clr_pending=4'b0100 one cycle.
REQ-036 Nest: accept prio 3 then prio 6, two mret -> t sequence 0,3,6,3,0; level 0,1,2,1,0.
REQ-037 Depth=4 filled (prios 1,2,3,4), is_interrupt with prio 7 -> irq_valid stays 0 until one mret, then offered.
REQ-038 level=1 (t=3), offer prio 5, irq_ready and mret same cycle -> t=5, level=1, stack top 0.
REQ-039 mret at level 0 -> err=1, t=0 unchanged; err holds until rst_n=0.
REQ-040 Assert rst_n=0 mid-OFFER (irq_ready=0) -> irq_valid=0 immediately, no clr_pending, t=0.

Source files
------------

// File: rtl/clic_pkg.sv
// Shared types and default sizing for the CLIC dispatch slice.
package clic_pkg;

  localparam int unsigned NrSourcesDef = 4;
  localparam int unsigned PrioWidthDef = 3;
  localparam int unsigned DepthDef     = 4;

  typedef enum logic [0:0] {
    StIdle,
    StOffer
  } clic_state_e;

endpackage

// File: rtl/clic_prio_stack.sv
// Threshold LIFO: saves the interrupted threshold on each nesting level.
// A simultaneous push and pop replaces the top entry in place.
module clic_prio_stack
  import clic_pkg::*;
#(
  parameter int unsigned Depth    = DepthDef,
  parameter int unsigned Width    = PrioWidthDef,
  localparam int unsigned LvlWidth = $clog2(Depth + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [Width-1:0]    data_i,
  output logic [Width-1:0]    top_o,
  output logic [LvlWidth-1:0] level_o,
  output logic                full_o,
  output logic                empty_o
);

  logic [Width-1:0]    mem_q [Depth];
  logic [Width-1:0]    mem_d [Depth];
  logic [LvlWidth-1:0] level_q, level_d;
  logic [LvlWidth-1:0] wr_idx;
  logic                wr_en;
  logic                do_push, do_pop;

  assign full_o  = (level_q == LvlWidth'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  always_comb begin
    mem_d   = mem_q;
    level_d = level_q;
    wr_en   = 1'b0;
    wr_idx  = level_q;
    top_o   = '0;
    do_pop  = pop_i && !empty_o;
    // A push on a full stack is only legal when the pop frees the top slot.
    do_push = push_i && (!full_o || do_pop);

    if (do_pop && do_push) begin
      wr_en  = 1'b1;
      wr_idx = level_q - LvlWidth'(1);
    end else if (do_push) begin
      wr_en   = 1'b1;
      level_d = level_q + LvlWidth'(1);
    end else if (do_pop) begin
      level_d = level_q - LvlWidth'(1);
    end

    for (int unsigned i = 0; i < Depth; i++) begin
      if (wr_en && (LvlWidth'(i) == wr_idx)) begin
        mem_d[i] = data_i;
      end
      if (LvlWidth'(i + 1) == level_q) begin
        top_o = mem_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/clic_dispatch.sv
// Offers the arbiter's winner to the core, tracks the nested threshold and
// pulses the pending-clear of the accepted source.
module clic_dispatch
  import clic_pkg::*;
#(
  parameter int unsigned NrSources = NrSourcesDef,
  parameter int unsigned PrioWidth = PrioWidthDef,
  parameter int unsigned Depth     = DepthDef,
  localparam int unsigned SrcWidth = $clog2(NrSources),
  localparam int unsigned LvlWidth = $clog2(Depth + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SrcWidth-1:0]  index,
  input  logic                 is_interrupt,
  input  logic [PrioWidth-1:0] win_prio,
  input  logic                 irq_ready,
  input  logic                 mret,
  output logic [PrioWidth-1:0] t,
  output logic                 irq_valid,
  output logic [SrcWidth-1:0]  irq_id,
  output logic [NrSources-1:0] clr_pending,
  output logic [LvlWidth-1:0]  level,
  output logic                 err
);

  clic_state_e          state_q, state_d;
  logic [SrcWidth-1:0]  irq_id_q, irq_id_d;
  logic [PrioWidth-1:0] prio_q, prio_d;
  logic [PrioWidth-1:0] t_q, t_d;
  logic [NrSources-1:0] clr_pending_q, clr_pending_d;
  logic                 err_q, err_d;

  logic                 handshake;
  logic                 pop_valid;
  logic [PrioWidth-1:0] stk_top, stk_push_data;
  logic                 stk_full, stk_empty;

  assign handshake = (state_q == StOffer) && irq_ready;
  assign pop_valid = mret && !stk_empty;
  // On return-and-reenter the saved slot must keep the returned-to threshold.
  assign stk_push_data = pop_valid ? stk_top : t_q;

  clic_prio_stack #(
    .Depth (Depth),
    .Width (PrioWidth)
  ) u_prio_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (handshake),
    .pop_i   (mret),
    .data_i  (stk_push_data),
    .top_o   (stk_top),
    .level_o (level),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_comb begin
    state_d       = state_q;
    irq_id_d      = irq_id_q;
    prio_d        = prio_q;
    t_d           = t_q;
    clr_pending_d = '0;
    err_d         = err_q | (mret & stk_empty);

    if (pop_valid) begin
      t_d = stk_top;
    end

    unique case (state_q)
      StIdle: begin
        if (is_interrupt && !stk_full) begin
          irq_id_d = index;
          prio_d   = win_prio;
          state_d  = StOffer;
        end
      end
      StOffer: begin
        if (irq_ready) begin
          t_d           = prio_q;
          clr_pending_d = {{(NrSources - 1){1'b0}}, 1'b1} << irq_id_q;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      irq_id_q      <= '0;
      prio_q        <= '0;
      t_q           <= '0;
      clr_pending_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      irq_id_q      <= irq_id_d;
      prio_q        <= prio_d;
      t_q           <= t_d;
      clr_pending_q <= clr_pending_d;
      err_q         <= err_d;
    end
  end

  assign t           = t_q;
  assign irq_valid   = (state_q == StOffer);
  assign irq_id      = irq_id_q;
  assign clr_pending = clr_pending_q;
  assign err         = err_q;

endmodule

// File: tb/tb_clic_dispatch.sv
// Directed scenarios plus random traffic against a queue-based reference model.
module tb_clic_dispatch;

  localparam int unsigned NrSources = 4;
  localparam int unsigned PrioWidth = 3;
  localparam int unsigned Depth     = 4;
  localparam int unsigned SrcWidth  = 2;
  localparam int unsigned LvlWidth  = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [SrcWidth-1:0]  index = '0;
  logic                 is_interrupt = 1'b0;
  logic [PrioWidth-1:0] win_prio = '0;
  logic                 irq_ready = 1'b0;
  logic                 mret = 1'b0;
  logic [PrioWidth-1:0] t;
  logic                 irq_valid;
  logic [SrcWidth-1:0]  irq_id;
  logic [NrSources-1:0] clr_pending;
  logic [LvlWidth-1:0]  level;
  logic                 err;

  clic_dispatch #(
    .NrSources (NrSources),
    .PrioWidth (PrioWidth),
    .Depth     (Depth)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .index        (index),
    .is_interrupt (is_interrupt),
    .win_prio     (win_prio),
    .irq_ready    (irq_ready),
    .mret         (mret),
    .t            (t),
    .irq_valid    (irq_valid),
    .irq_id       (irq_id),
    .clr_pending  (clr_pending),
    .level        (level),
    .err          (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: saved thresholds as a queue, nesting level is its size.
  int m_stack[$];
  int m_t, m_id, m_prio, m_clr;
  bit m_offer, m_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stack.delete();
    m_t = 0; m_id = 0; m_prio = 0; m_clr = 0; m_offer = 0; m_err = 0;
  endtask

  task automatic model_step();
    int  sz0;
    int  new_t;
    bit  hs;
    sz0   = m_stack.size();
    hs    = m_offer && irq_ready;
    new_t = m_t;
    m_clr = 0;
    if (mret) begin
      if (sz0 == 0) m_err = 1;
      else new_t = m_stack.pop_back();
    end
    if (hs) begin
      // Enter the new handler from whatever threshold is now current.
      m_stack.push_back(new_t);
      new_t   = m_prio;
      m_clr   = 1 << m_id;
      m_offer = 0;
    end else if (!m_offer && is_interrupt && sz0 < Depth) begin
      m_offer = 1;
      m_id    = int'(index);
      m_prio  = int'(win_prio);
    end
    m_t = new_t;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_t"}, 32'(t), 32'(m_t));
    check_eq({tag, "_level"}, 32'(level), 32'(m_stack.size()));
    check_eq({tag, "_valid"}, 32'(irq_valid), 32'(m_offer));
    if (m_offer) check_eq({tag, "_id"}, 32'(irq_id), 32'(m_id));
    check_eq({tag, "_clr"}, 32'(clr_pending), 32'(m_clr));
    check_eq({tag, "_err"}, 32'(err), 32'(m_err));
  endtask

  task automatic drive(input bit intr, input int idx, input int prio, input bit rdy,
                       input bit mr);
    is_interrupt = intr;
    index        = SrcWidth'(idx);
    win_prio     = PrioWidth'(prio);
    irq_ready    = rdy;
    mret         = mr;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic accept(input int idx, input int prio);
    drive(1, idx, prio, 0, 0);
    step("acc_offer");
    drive(0, 0, 0, 1, 0);
    step("acc_hs");
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // Single offer and handshake
    drive(1, 2, 5, 0, 0);
    step("r35_a");
    check_eq("r35_valid", 32'(irq_valid), 32'd1);
    check_eq("r35_id", 32'(irq_id), 32'd2);
    drive(0, 0, 0, 1, 0);
    step("r35_b");
    check_eq("r35_t", 32'(t), 32'd5);
    check_eq("r35_level", 32'(level), 32'd1);
    check_eq("r35_clr", 32'(clr_pending), 32'b0100);
    check_eq("r35_valid_off", 32'(irq_valid), 32'd0);
    drive(0, 0, 0, 0, 0);
    step("r35_c");
    check_eq("r35_clr_once", 32'(clr_pending), 32'd0);

    // Nesting and unwinding
    do_reset();
    accept(0, 3);
    check_eq("r36_t1", 32'(t), 32'd3);
    check_eq("r36_l1", 32'(level), 32'd1);
    accept(1, 6);
    check_eq("r36_t2", 32'(t), 32'd6);
    check_eq("r36_l2", 32'(level), 32'd2);
    drive(0, 0, 0, 0, 1);
    step("r36_m1");
    check_eq("r36_t3", 32'(t), 32'd3);
    check_eq("r36_l3", 32'(level), 32'd1);
    step("r36_m2");
    check_eq("r36_t4", 32'(t), 32'd0);
    check_eq("r36_l4", 32'(level), 32'd0);

    // Full stack blocks offers until a return frees a slot
    do_reset();
    for (int p = 1; p <= 4; p++) accept(p % 4, p);
    check_eq("r37_full", 32'(level), 32'd4);
    drive(1, 3, 7, 0, 0);
    step("r37_a");
    check_eq("r37_noval_a", 32'(irq_valid), 32'd0);
    step("r37_b");
    check_eq("r37_noval_b", 32'(irq_valid), 32'd0);
    drive(1, 3, 7, 0, 1);
    step("r37_m");
    check_eq("r37_t_pop", 32'(t), 32'd3);
    drive(1, 3, 7, 0, 0);
    step("r37_c");
    check_eq("r37_offered", 32'(irq_valid), 32'd1);
    drive(0, 0, 0, 1, 0);
    step("r37_hs");
    check_eq("r37_t_new", 32'(t), 32'd7);

    // Return and re-enter in the same cycle
    do_reset();
    accept(0, 3);
    drive(1, 1, 5, 0, 0);
    step("r38_a");
    drive(0, 0, 0, 1, 1);
    step("r38_b");
    check_eq("r38_t", 32'(t), 32'd5);
    check_eq("r38_level", 32'(level), 32'd1);
    drive(0, 0, 0, 0, 1);
    step("r38_c");
    check_eq("r38_top", 32'(t), 32'd0);

    // Return with nothing to return from
    do_reset();
    drive(0, 0, 0, 0, 1);
    step("r39_a");
    check_eq("r39_err", 32'(err), 32'd1);
    check_eq("r39_t", 32'(t), 32'd0);
    drive(0, 0, 0, 0, 0);
    repeat (3) step("r39_hold");
    check_eq("r39_sticky", 32'(err), 32'd1);
    do_reset();
    check_eq("r39_cleared", 32'(err), 32'd0);

    // Asynchronous reset in the middle of an offer
    accept(1, 2);
    drive(1, 2, 4, 0, 0);
    step("r40_a");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("r40_valid", 32'(irq_valid), 32'd0);
    check_eq("r40_clr", 32'(clr_pending), 32'd0);
    check_eq("r40_t", 32'(t), 32'd0);
    check_eq("r40_level", 32'(level), 32'd0);
    drive(0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("r40_after");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 9) < 6, int'($urandom_range(0, NrSources - 1)),
              int'($urandom_range(0, (1 << PrioWidth) - 1)), $urandom_range(0, 1) == 1,
              $urandom_range(0, 4) == 0);
        step("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
